// File: rtl/channel_bank_if.sv
// Bundle between host config/readout, the channel array and channel_bank.
// Flattened vectors carry channel k at [k*W +: W].
interface channel_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DOPP_W = 16,
  parameter int I2Q2_W = 32
);
  logic                       cfg_wr;
  logic [CH_W-1:0]            cfg_ch;
  logic [DOPP_W-1:0]          cfg_doppler;
  logic [4:0]                 cfg_prn;

  logic [NUM_CH-1:0]          ch_reset;
  logic [NUM_CH*DOPP_W-1:0]   ch_doppler_early;
  logic [NUM_CH*DOPP_W-1:0]   ch_doppler_prompt;
  logic [NUM_CH*DOPP_W-1:0]   ch_doppler_late;
  logic [NUM_CH*5-1:0]        ch_prn;

  logic [NUM_CH-1:0]          ch_i2q2_valid;
  logic [NUM_CH*I2Q2_W-1:0]   ch_i2q2_early;
  logic [NUM_CH*I2Q2_W-1:0]   ch_i2q2_prompt;
  logic [NUM_CH*I2Q2_W-1:0]   ch_i2q2_late;

  logic                       out_valid;
  logic                       out_ready;
  logic [CH_W-1:0]            out_ch;
  logic [I2Q2_W-1:0]          out_early;
  logic [I2Q2_W-1:0]          out_prompt;
  logic [I2Q2_W-1:0]          out_late;
  logic [NUM_CH-1:0]          overrun;

  modport slave (
    input  cfg_wr, cfg_ch, cfg_doppler, cfg_prn,
    input  ch_i2q2_valid, ch_i2q2_early, ch_i2q2_prompt, ch_i2q2_late,
    input  out_ready,
    output ch_reset, ch_doppler_early, ch_doppler_prompt, ch_doppler_late, ch_prn,
    output out_valid, out_ch, out_early, out_prompt, out_late, overrun
  );

  modport master (
    output cfg_wr, cfg_ch, cfg_doppler, cfg_prn,
    output ch_i2q2_valid, ch_i2q2_early, ch_i2q2_prompt, ch_i2q2_late,
    output out_ready,
    input  ch_reset, ch_doppler_early, ch_doppler_prompt, ch_doppler_late, ch_prn,
    input  out_valid, out_ch, out_early, out_prompt, out_late, overrun
  );
endinterface

// File: rtl/channel_bank.sv
// Multi-channel front end: per-channel carrier/code config plus a round-robin
// collector that serialises I2+Q2 triplets onto one valid/ready stream.

// One channel: config registers, restart pulse and the result holding slot.
module channel_bank_lane #(
  parameter int                DOPP_W       = 16,
  parameter int                I2Q2_W       = 32,
  parameter logic [DOPP_W-1:0] DOPP_BIN_INC = 16'd100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic [DOPP_W-1:0] i_cfg_doppler,
  input  logic [4:0]        i_cfg_prn,
  input  logic              i_vld,
  input  logic [I2Q2_W-1:0] i_e,
  input  logic [I2Q2_W-1:0] i_p,
  input  logic [I2Q2_W-1:0] i_l,
  input  logic              i_xfer,
  output logic              o_ch_reset,
  output logic [DOPP_W-1:0] o_de,
  output logic [DOPP_W-1:0] o_dp,
  output logic [DOPP_W-1:0] o_dl,
  output logic [4:0]        o_prn,
  output logic              o_pend,
  output logic              o_ovr,
  output logic [I2Q2_W-1:0] o_he,
  output logic [I2Q2_W-1:0] o_hp,
  output logic [I2Q2_W-1:0] o_hl
);
  logic              r_ch_reset;
  logic [DOPP_W-1:0] r_de, r_dp, r_dl;
  logic [4:0]        r_prn;
  logic              r_pend, r_ovr;
  logic [I2Q2_W-1:0] r_he, r_hp, r_hl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch_reset <= 1'b1;
      r_de       <= '0;
      r_dp       <= '0;
      r_dl       <= '0;
      r_prn      <= '0;
      r_pend     <= 1'b0;
      r_ovr      <= 1'b0;
      r_he       <= '0;
      r_hp       <= '0;
      r_hl       <= '0;
    end else begin
      r_ch_reset <= i_wr;
      // A config write restarts the channel, so any in-flight result is stale.
      if (i_wr) begin
        r_dp   <= i_cfg_doppler;
        r_de   <= i_cfg_doppler + DOPP_BIN_INC;
        r_dl   <= i_cfg_doppler - DOPP_BIN_INC;
        r_prn  <= i_cfg_prn;
        r_pend <= 1'b0;
        r_ovr  <= 1'b0;
      end else if (i_vld) begin
        r_he   <= i_e;
        r_hp   <= i_p;
        r_hl   <= i_l;
        r_pend <= 1'b1;
        if (r_pend && !i_xfer) r_ovr <= 1'b1;
      end else if (i_xfer) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_ch_reset = r_ch_reset;
  assign o_de       = r_de;
  assign o_dp       = r_dp;
  assign o_dl       = r_dl;
  assign o_prn      = r_prn;
  assign o_pend     = r_pend;
  assign o_ovr      = r_ovr;
  assign o_he       = r_he;
  assign o_hp       = r_hp;
  assign o_hl       = r_hl;
endmodule

module channel_bank #(
  parameter int                NUM_CH       = 4,
  parameter int                CH_W         = 2,
  parameter int                DOPP_W       = 16,
  parameter int                I2Q2_W       = 32,
  parameter logic [DOPP_W-1:0] DOPP_BIN_INC = 16'd100
) (
  input logic           clk,
  input logic           global_reset_n,
  channel_bank_if.slave bus
);
  logic [NUM_CH-1:0][DOPP_W-1:0] w_de, w_dp, w_dl;
  logic [NUM_CH-1:0][4:0]        w_prn;
  logic [NUM_CH-1:0][I2Q2_W-1:0] w_ie, w_ip, w_il;
  logic [NUM_CH-1:0][I2Q2_W-1:0] w_he, w_hp, w_hl;
  logic [NUM_CH-1:0]             w_wr, w_xfer, w_pend, w_ovr, w_ch_reset, w_req;

  logic              w_free;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [I2Q2_W-1:0] w_sel_e, w_sel_p, w_sel_l;
  int                w_j;

  logic              r_out_valid;
  logic [CH_W-1:0]   r_out_ch;
  logic [I2Q2_W-1:0] r_out_e, r_out_p, r_out_l;
  logic [CH_W-1:0]   r_ptr;

  assign w_ie = bus.ch_i2q2_early;
  assign w_ip = bus.ch_i2q2_prompt;
  assign w_il = bus.ch_i2q2_late;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign w_wr[k]   = bus.cfg_wr && (bus.cfg_ch == CH_W'(k));
    assign w_xfer[k] = w_free && w_gnt_vld && (w_gnt_idx == CH_W'(k));

    channel_bank_lane #(
      .DOPP_W       (DOPP_W),
      .I2Q2_W       (I2Q2_W),
      .DOPP_BIN_INC (DOPP_BIN_INC)
    ) u_lane (
      .clk           (clk),
      .rst_n         (global_reset_n),
      .i_wr          (w_wr[k]),
      .i_cfg_doppler (bus.cfg_doppler),
      .i_cfg_prn     (bus.cfg_prn),
      .i_vld         (bus.ch_i2q2_valid[k]),
      .i_e           (w_ie[k]),
      .i_p           (w_ip[k]),
      .i_l           (w_il[k]),
      .i_xfer        (w_xfer[k]),
      .o_ch_reset    (w_ch_reset[k]),
      .o_de          (w_de[k]),
      .o_dp          (w_dp[k]),
      .o_dl          (w_dl[k]),
      .o_prn         (w_prn[k]),
      .o_pend        (w_pend[k]),
      .o_ovr         (w_ovr[k]),
      .o_he          (w_he[k]),
      .o_hp          (w_hp[k]),
      .o_hl          (w_hl[k])
    );
  end

  // A slot being rewritten this cycle is discarded, so it must not win a grant.
  assign w_req  = w_pend & ~w_wr;
  assign w_free = !r_out_valid || bus.out_ready;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_sel_e   = '0;
    w_sel_p   = '0;
    w_sel_l   = '0;
    w_j       = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= NUM_CH) w_j = w_j - NUM_CH;
      for (int k = 0; k < NUM_CH; k++) begin
        if (!w_gnt_vld && (w_j == k) && w_req[k]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = CH_W'(k);
          w_sel_e   = w_he[k];
          w_sel_p   = w_hp[k];
          w_sel_l   = w_hl[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!global_reset_n) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_e     <= '0;
      r_out_p     <= '0;
      r_out_l     <= '0;
      r_ptr       <= CH_W'(NUM_CH - 1);
    end else if (w_free) begin
      if (w_gnt_vld) begin
        r_out_valid <= 1'b1;
        r_out_ch    <= w_gnt_idx;
        r_out_e     <= w_sel_e;
        r_out_p     <= w_sel_p;
        r_out_l     <= w_sel_l;
        r_ptr       <= w_gnt_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.ch_reset          = w_ch_reset;
  assign bus.ch_doppler_early  = w_de;
  assign bus.ch_doppler_prompt = w_dp;
  assign bus.ch_doppler_late   = w_dl;
  assign bus.ch_prn            = w_prn;
  assign bus.overrun           = w_ovr;
  assign bus.out_valid         = r_out_valid;
  assign bus.out_ch            = r_out_ch;
  assign bus.out_early         = r_out_e;
  assign bus.out_prompt        = r_out_p;
  assign bus.out_late          = r_out_l;
endmodule

// File: tb/tb_channel_bank.sv
// Bench for channel_bank: directed scenarios against fixed values, then random
// traffic against a cycle-level reference model of the bank's rules.
module tb_channel_bank;
  localparam int N  = 4;
  localparam int CW = 3;
  localparam int DW = 16;
  localparam int IW = 32;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  channel_bank_if #(.NUM_CH(N), .CH_W(CW), .DOPP_W(DW), .I2Q2_W(IW)) bus ();

  channel_bank #(.NUM_CH(N), .CH_W(CW), .DOPP_W(DW), .I2Q2_W(IW), .DOPP_BIN_INC(16'd100)) dut (
    .clk            (clk),
    .global_reset_n (rst_n),
    .bus            (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [DW-1:0] m_de[N], m_dp[N], m_dl[N];
  logic [4:0]    m_prn[N];
  logic [IW-1:0] m_he[N], m_hp[N], m_hl[N];
  bit            m_pend[N], m_ovr[N], m_chrst[N];
  bit            m_oval;
  int            m_och, m_ptr;
  logic [IW-1:0] m_oe, m_op, m_ol;

  task automatic model_update();
    bit free, gv;
    int gi;
    bit wr[N];
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_de[k] = 0; m_dp[k] = 0; m_dl[k] = 0; m_prn[k] = 0;
        m_he[k] = 0; m_hp[k] = 0; m_hl[k] = 0;
        m_pend[k] = 0; m_ovr[k] = 0; m_chrst[k] = 1;
      end
      m_oval = 0; m_och = 0; m_oe = 0; m_op = 0; m_ol = 0; m_ptr = N - 1;
    end else begin
      free = !m_oval || bus.out_ready;
      for (int k = 0; k < N; k++) wr[k] = bus.cfg_wr && (int'(bus.cfg_ch) == k);
      gv = 0; gi = 0;
      if (free) begin
        for (int i = 1; i <= N; i++) begin
          int j = (m_ptr + i) % N;
          if (!gv && m_pend[j] && !wr[j]) begin gv = 1; gi = j; end
        end
        if (gv) begin
          m_oval = 1; m_och = gi; m_ptr = gi;
          m_oe = m_he[gi]; m_op = m_hp[gi]; m_ol = m_hl[gi];
        end else m_oval = 0;
      end
      for (int k = 0; k < N; k++) begin
        m_chrst[k] = wr[k];
        if (wr[k]) begin
          m_dp[k] = bus.cfg_doppler;
          m_de[k] = bus.cfg_doppler + 16'd100;
          m_dl[k] = bus.cfg_doppler - 16'd100;
          m_prn[k] = bus.cfg_prn;
          m_pend[k] = 0; m_ovr[k] = 0;
        end else if (bus.ch_i2q2_valid[k]) begin
          if (m_pend[k] && !(gv && gi == k)) m_ovr[k] = 1;
          m_he[k] = bus.ch_i2q2_early[k*IW +: IW];
          m_hp[k] = bus.ch_i2q2_prompt[k*IW +: IW];
          m_hl[k] = bus.ch_i2q2_late[k*IW +: IW];
          m_pend[k] = 1;
        end else if (gv && gi == k) m_pend[k] = 0;
      end
    end
  endtask

  // Advance one edge; inputs are driven 1 time unit after each edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cfg(input int ch, input logic [15:0] d, input logic [4:0] p);
    bus.cfg_wr = 1'b1; bus.cfg_ch = CW'(ch); bus.cfg_doppler = d; bus.cfg_prn = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(); cycle();
    n_chk++; if (bus.ch_reset !== 4'b1111) begin n_err++; $display("FAIL reset_ch_reset got %b want 1111", bus.ch_reset); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_chk++; if (bus.overrun !== 4'b0000) begin n_err++; $display("FAIL reset_overrun got %b want 0000", bus.overrun); end
    n_chk++; if (bus.ch_doppler_prompt !== 64'h0) begin n_err++; $display("FAIL reset_doppler got %h want 0", bus.ch_doppler_prompt); end
  endtask

  task automatic test_config();
    rst_n = 1'b1;
    cycle();
    n_chk++; if (bus.ch_reset !== 4'b0000) begin n_err++; $display("FAIL cfg_release_ch_reset got %b want 0000", bus.ch_reset); end
    cfg(2, 16'h0010, 5'd7);
    cycle();
    bus.cfg_wr = 1'b0;
    n_chk++; if (bus.ch_doppler_early[2*DW +: DW] !== 16'h0074) begin n_err++; $display("FAIL cfg_early got %h want 0074", bus.ch_doppler_early[2*DW +: DW]); end
    n_chk++; if (bus.ch_doppler_prompt[2*DW +: DW] !== 16'h0010) begin n_err++; $display("FAIL cfg_prompt got %h want 0010", bus.ch_doppler_prompt[2*DW +: DW]); end
    n_chk++; if (bus.ch_doppler_late[2*DW +: DW] !== 16'hFFAC) begin n_err++; $display("FAIL cfg_late got %h want ffac", bus.ch_doppler_late[2*DW +: DW]); end
    n_chk++; if (bus.ch_prn !== 20'h01C00) begin n_err++; $display("FAIL cfg_prn got %h want 01c00", bus.ch_prn); end
    n_chk++; if (bus.ch_reset !== 4'b0100) begin n_err++; $display("FAIL cfg_ch_reset_pulse got %b want 0100", bus.ch_reset); end
    n_chk++; if ({bus.ch_doppler_prompt[3*DW +: DW], bus.ch_doppler_prompt[0 +: 2*DW]} !== 48'h0) begin
      n_err++; $display("FAIL cfg_others got %h want 0", bus.ch_doppler_prompt); end
    cycle();
    n_chk++; if (bus.ch_reset !== 4'b0000) begin n_err++; $display("FAIL cfg_ch_reset_end got %b want 0000", bus.ch_reset); end
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    bus.ch_i2q2_valid = 4'hF;
    for (int k = 0; k < N; k++) begin
      bus.ch_i2q2_early[k*IW +: IW]  = IW'(k + 32'h100);
      bus.ch_i2q2_prompt[k*IW +: IW] = IW'(k + 1);
      bus.ch_i2q2_late[k*IW +: IW]   = IW'(k + 32'h200);
    end
    cycle();
    bus.ch_i2q2_valid = '0;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency got %b want 0", bus.out_valid); end
    for (int k = 0; k < N; k++) begin
      cycle();
      n_chk++;
      if ({bus.out_valid, bus.out_ch, bus.out_prompt, bus.out_early} !== {1'b1, CW'(k), IW'(k + 1), IW'(k + 32'h100)}) begin
        n_err++; $display("FAIL stream_beat%0d got v=%b ch=%0d p=%0d e=%h want v=1 ch=%0d p=%0d", k,
                          bus.out_valid, bus.out_ch, bus.out_prompt, bus.out_early, k, k + 1);
      end
    end
    cycle();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.overrun !== 4'b0) begin
      n_err++; $display("FAIL stream_end got v=%b ovr=%b want v=0 ovr=0000", bus.out_valid, bus.overrun); end
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    bus.ch_i2q2_valid = 4'b0001; bus.ch_i2q2_prompt[0 +: IW] = 32'h77;
    cycle();
    bus.ch_i2q2_valid = 4'b0000;
    cycle();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd0) begin
      n_err++; $display("FAIL ovr_fill got v=%b ch=%0d want v=1 ch=0", bus.out_valid, bus.out_ch); end
    bus.ch_i2q2_valid = 4'b0010; bus.ch_i2q2_prompt[IW +: IW] = 32'd5;
    cycle();
    bus.ch_i2q2_prompt[IW +: IW] = 32'd9;
    cycle();
    bus.ch_i2q2_valid = 4'b0000;
    n_chk++; if (bus.overrun !== 4'b0010 || bus.out_ch !== 3'd0 || bus.out_prompt !== 32'h77) begin
      n_err++; $display("FAIL ovr_flag got ovr=%b ch=%0d p=%h want ovr=0010 ch=0 p=77", bus.overrun, bus.out_ch, bus.out_prompt); end
    bus.out_ready = 1'b1;
    cycle();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd1 || bus.out_prompt !== 32'd9) begin
      n_err++; $display("FAIL ovr_result got v=%b ch=%0d p=%0d want v=1 ch=1 p=9", bus.out_valid, bus.out_ch, bus.out_prompt); end
    cycle();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.overrun !== 4'b0010) begin
      n_err++; $display("FAIL ovr_sticky got v=%b ovr=%b want v=0 ovr=0010", bus.out_valid, bus.overrun); end
    cfg(1, 16'h0200, 5'd3);
    cycle();
    bus.cfg_wr = 1'b0;
    n_chk++; if (bus.overrun !== 4'b0000) begin n_err++; $display("FAIL ovr_clear got %b want 0000", bus.overrun); end
  endtask

  task automatic test_priority();
    bus.out_ready = 1'b1;
    bus.ch_i2q2_valid = 4'b0001;
    cycle();
    bus.ch_i2q2_valid = 4'b0000;
    cycle();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd0) begin
      n_err++; $display("FAIL prio_setup got v=%b ch=%0d want v=1 ch=0", bus.out_valid, bus.out_ch); end
    bus.ch_i2q2_valid = 4'b1001;
    cycle();
    bus.ch_i2q2_valid = 4'b0000;
    n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL prio_gap got %b want 0", bus.out_valid); end
    cycle();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd3) begin
      n_err++; $display("FAIL prio_first got v=%b ch=%0d want v=1 ch=3", bus.out_valid, bus.out_ch); end
    cycle();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd0) begin
      n_err++; $display("FAIL prio_second got v=%b ch=%0d want v=1 ch=0", bus.out_valid, bus.out_ch); end
    cycle();
  endtask

  task automatic test_cfg_collision();
    bus.out_ready = 1'b1;
    cfg(1, 16'h0300, 5'd4);
    bus.ch_i2q2_valid = 4'b0010;
    cycle();
    bus.cfg_wr = 1'b0; bus.ch_i2q2_valid = 4'b0000;
    n_chk++; if (bus.overrun[1] !== 1'b0 || bus.ch_doppler_early[DW +: DW] !== 16'h0364) begin
      n_err++; $display("FAIL coll_cfg got ovr1=%b early=%h want ovr1=0 early=0364", bus.overrun[1], bus.ch_doppler_early[DW +: DW]); end
    cycle();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL coll_no_output got %b want 0", bus.out_valid); end
    cfg(5, 16'h1234, 5'd9);
    cycle();
    bus.cfg_wr = 1'b0;
    n_chk++; if (bus.ch_reset !== 4'b0000 || bus.ch_doppler_prompt !== 64'h0000_0010_0300_0000) begin
      n_err++; $display("FAIL cfg_out_of_range got rst=%b prompt=%h want 0000 0000001003000000", bus.ch_reset, bus.ch_doppler_prompt); end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    bus.ch_i2q2_valid = 4'hF;
    cycle(); cycle();
    bus.ch_i2q2_valid = 4'h0;
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd1 || bus.overrun !== 4'b1101) begin
      n_err++; $display("FAIL mid_setup got v=%b ch=%0d ovr=%b want v=1 ch=1 ovr=1101", bus.out_valid, bus.out_ch, bus.overrun); end
    rst_n = 1'b0;
    cycle();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.overrun !== 4'b0 || bus.ch_reset !== 4'b1111) begin
      n_err++; $display("FAIL mid_reset got v=%b ovr=%b rst=%b want 0 0000 1111", bus.out_valid, bus.overrun, bus.ch_reset); end
    rst_n = 1'b1; bus.out_ready = 1'b1;
    cycle(); cycle();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_pending_cleared got %b want 0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [N*DW-1:0] xe, xp, xl;
    logic [N*5-1:0]  xprn;
    logic [N-1:0]    xo, xr;
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.cfg_wr = ($urandom_range(0, 7) == 0);
      bus.cfg_ch = CW'($urandom_range(0, 7));
      bus.cfg_doppler = DW'($urandom);
      bus.cfg_prn = 5'($urandom);
      bus.ch_i2q2_valid = N'($urandom & $urandom);
      bus.ch_i2q2_early = {$urandom, $urandom, $urandom, $urandom};
      bus.ch_i2q2_prompt = {$urandom, $urandom, $urandom, $urandom};
      bus.ch_i2q2_late = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 9) < 6);
      cycle();
      for (int k = 0; k < N; k++) begin
        xe[k*DW +: DW] = m_de[k]; xp[k*DW +: DW] = m_dp[k]; xl[k*DW +: DW] = m_dl[k];
        xprn[k*5 +: 5] = m_prn[k]; xo[k] = m_ovr[k]; xr[k] = m_chrst[k];
      end
      n_chk++;
      if ({bus.out_valid, bus.out_ch} !== {m_oval, CW'(m_och)} ||
          {bus.out_early, bus.out_prompt, bus.out_late} !== {m_oe, m_op, m_ol}) begin
        n_err++; $display("FAIL rand_out c=%0d got v=%b ch=%0d p=%h want v=%b ch=%0d p=%h",
                          c, bus.out_valid, bus.out_ch, bus.out_prompt, m_oval, m_och, m_op);
      end
      n_chk++;
      if (bus.overrun !== xo || bus.ch_reset !== xr) begin
        n_err++; $display("FAIL rand_flags c=%0d got ovr=%b rst=%b want ovr=%b rst=%b", c, bus.overrun, bus.ch_reset, xo, xr);
      end
      n_chk++;
      if (bus.ch_doppler_early !== xe || bus.ch_doppler_prompt !== xp || bus.ch_doppler_late !== xl || bus.ch_prn !== xprn) begin
        n_err++; $display("FAIL rand_cfg c=%0d got p=%h e=%h want p=%h e=%h", c, bus.ch_doppler_prompt, bus.ch_doppler_early, xp, xe);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_doppler = '0; bus.cfg_prn = '0;
    bus.ch_i2q2_valid = '0; bus.ch_i2q2_early = '0; bus.ch_i2q2_prompt = '0; bus.ch_i2q2_late = '0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_config();
    test_stream();
    test_overrun();
    test_priority();
    test_cfg_collision();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
